// File: rtl/arb_requester.sv
`default_nettype none
// ============================================================================
// Module : arb_requester
// Client agent for a fixed-priority arbiter. It holds req for a whole burst and
// moves beats only while gnt is high. ARB_REQ_TIMEOUT_EN adds a starvation flag.
// Rev    : 1.0
// ============================================================================
module arb_requester #(
  parameter int DATA_W         = 32,
  parameter int MAX_BURST      = 16,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int LEN_W          = $clog2(MAX_BURST) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              req,
  input  logic              gnt,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_last,
  output logic              busy,
  output logic              starve
);

  typedef enum logic [0:0] {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t             state;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   beat_cnt;
  logic [LEN_W-1:0]   len_clamped;
  logic               xfer;
  logic               last_beat;

  assign len_clamped = (cmd_len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : cmd_len;

  // gnt is only honoured while this client owns a burst.
  assign xfer      = (state == OWN) && gnt && in_valid;
  assign last_beat = (beat_cnt == (len - LEN_W'(1)));
  assign in_ready  = (state == OWN) && gnt;
  assign bus_valid = xfer;
  assign bus_data  = xfer ? in_data : '0;
  assign bus_last  = xfer && last_beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len       <= '0;
      beat_cnt  <= '0;
      req       <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Zero-length commands are accepted and dropped without requesting.
          if (cmd_valid && (len_clamped != '0)) begin
            len       <= len_clamped;
            beat_cnt  <= '0;
            state     <= OWN;
            req       <= 1'b1;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        OWN: begin
          if (xfer) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
            if (last_beat) begin
              state     <= IDLE;
              req       <= 1'b0;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          req       <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_REQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_cnt;

  // starve rises on the edge that ends the TIMEOUT_CYCLES-th consecutive stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      starve   <= 1'b0;
    end else if ((state != OWN) || (xfer && last_beat)) begin
      wait_cnt <= '0;
      starve   <= 1'b0;
    end else if (gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_W'(TIMEOUT_CYCLES)) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
      if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1))
        starve <= 1'b1;
    end
  end
`else
  assign starve = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_arb_requester.sv
`default_nettype none
// Bench for arb_requester: DUT sits on bit 3 of a modelled 8-bit fixed-priority
// arbiter (bit 0 highest). A burst-level model is checked every cycle.
module tb_arb_requester;

`ifdef ARB_REQ_TIMEOUT_EN
  localparam int TO_EN = 1;
  localparam int TO    = 8;
`else
  localparam int TO_EN = 0;
  localparam int TO    = 64;
`endif
  localparam int LEN_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              req;
  logic              gnt;
  logic              bus_valid;
  logic [31:0]       bus_data;
  logic              bus_last;
  logic              busy;
  logic              starve;

  logic [7:0]        other_req;
  logic [31:0]       src_data [64];
  logic [5:0]        src_idx;

  int tests = 0;
  int fails = 0;
  int beats = 0;
  int lasts = 0;
  int sb_idx = 0;

  // Burst-level model state
  bit m_own    = 1'b0;
  int m_rem    = 0;
  int m_wait   = 0;
  bit m_starve = 1'b0;

  assign gnt     = req && (other_req[2:0] == 3'b000);
  assign in_data = src_data[src_idx];

  arb_requester #(
    .DATA_W(32), .MAX_BURST(16), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .req(req), .gnt(gnt),
    .bus_valid(bus_valid), .bus_data(bus_data), .bus_last(bus_last),
    .busy(busy), .starve(starve)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_finished"}, busy, 0);
  endtask

  // Per-cycle compare against the model, sampled mid-low-phase.
  initial begin : compare
    bit e_bv, s_cv, s_gnt, s_inv, adv;
    int s_len;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        m_own = 0; m_rem = 0; m_wait = 0; m_starve = 0;
      end
      e_bv = m_own && gnt && in_valid;
      chk("req", req, m_own);
      chk("cmd_ready", cmd_ready, !m_own);
      chk("busy", busy, m_own);
      chk("in_ready", in_ready, m_own && gnt);
      chk("bus_valid", bus_valid, e_bv);
      chk("bus_data", bus_data, e_bv ? in_data : 32'h0);
      chk("bus_last", bus_last, e_bv && (m_rem == 1));
      chk("starve", starve, (TO_EN != 0) && m_starve);
      if (bus_valid) begin
        beats++;
        if (bus_last) lasts++;
        chk("beat_order", bus_data, src_data[sb_idx]);
        sb_idx++;
      end
      adv   = in_valid && in_ready;
      s_cv  = cmd_valid;
      s_len = int'(cmd_len);
      s_gnt = gnt;
      s_inv = in_valid;
      if (rst_n) begin
        if (!m_own) begin
          if (s_cv && s_len != 0) begin
            m_own = 1;
            m_rem = (s_len > 16) ? 16 : s_len;
            m_wait = 0;
          end
        end else begin
          if (s_gnt) m_wait = 0;
          else begin
            if (m_wait < TO) m_wait++;
            if (m_wait == TO) m_starve = 1;
          end
          if (s_gnt && s_inv) begin
            m_rem--;
            if (m_rem == 0) begin
              m_own = 0; m_starve = 0; m_wait = 0;
            end
          end
        end
      end
      @(posedge clk);
      if (adv) src_idx = src_idx + 6'd1;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    for (int i = 0; i < 64; i++) src_data[i] = 32'hD000_0000 + i * 32'h0001_0111;
    src_idx = '0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; in_valid = 1'b0; other_req = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Simple 4-beat burst; a lower-priority requester must not interfere
    @(negedge clk);
    beats = 0; lasts = 0; other_req = 8'h20;
    cmd_valid = 1'b1; cmd_len = 5'd4; in_valid = 1'b1;
    #3 chk("t2_req_before_accept", req, 0);
    @(negedge clk); cmd_valid = 1'b0;
    #3 chk("t2_req_latency", req, 1);
    wait_idle("t2", 20);
    chk("t2_beats", beats, 4);
    chk("t2_lasts", lasts, 1);
    chk("t2_req_dropped", req, 0);
    other_req = 8'h00;
    @(negedge clk);

    // Higher-priority client steals gnt for 5 cycles mid-burst
    @(negedge clk);
    beats = 0; lasts = 0;
    cmd_valid = 1'b1; cmd_len = 5'd3; in_valid = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk); other_req = 8'h01;
    repeat (5) @(negedge clk);
    #3 chk("t3_beats_during_stall", beats, 1);
    chk("t3_req_held", req, 1);
    other_req = 8'h00;
    wait_idle("t3", 20);
    chk("t3_beats", beats, 3);
    chk("t3_lasts", lasts, 1);
    @(negedge clk);

    // Source bubbles while granted
    @(negedge clk);
    beats = 0; lasts = 0;
    cmd_valid = 1'b1; cmd_len = 5'd2; in_valid = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    #3 chk("t4_beats_in_bubble", beats, 1);
    chk("t4_req_held", req, 1);
    @(negedge clk); in_valid = 1'b1;
    wait_idle("t4", 20);
    chk("t4_beats", beats, 2);
    chk("t4_lasts", lasts, 1);
    @(negedge clk);

    // Zero-length command, then an over-long command clamped to 16
    @(negedge clk);
    beats = 0; lasts = 0;
    cmd_valid = 1'b1; cmd_len = 5'd0;
    #3 chk("t5_zero_ready", cmd_ready, 1);
    @(negedge clk); cmd_valid = 1'b0;
    #3 chk("t5_zero_no_req", req, 0);
    chk("t5_zero_not_busy", busy, 0);
    @(negedge clk);
    #3 chk("t5_zero_still_no_req", req, 0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_len = 5'd20; in_valid = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    wait_idle("t5", 40);
    chk("t5_clamped_beats", beats, 16);
    chk("t5_lasts", lasts, 1);
    @(negedge clk);

    // Starved for 10 cycles from the start of ownership
    @(negedge clk);
    beats = 0; lasts = 0;
    cmd_valid = 1'b1; cmd_len = 5'd2; in_valid = 1'b1; other_req = 8'h01;
    @(negedge clk); cmd_valid = 1'b0;
    repeat (7) @(negedge clk);
    #3 chk("t6_starve_before", starve, 0);
    @(negedge clk);
    #3 chk("t6_starve_after8", starve, TO_EN);
    chk("t6_req_kept", req, 1);
    @(negedge clk);
    @(negedge clk); other_req = 8'h00;
    #3 chk("t6_starve_sticky", starve, TO_EN);
    chk("t6_beats_stalled", beats, 0);
    wait_idle("t6", 20);
    chk("t6_starve_cleared", starve, 0);
    chk("t6_beats", beats, 2);
    @(negedge clk);

    // Asynchronous reset in the middle of a burst
    @(negedge clk);
    cmd_valid = 1'b1; cmd_len = 5'd5; in_valid = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("t1_rst_req", req, 0);
    chk("t1_rst_bus_valid", bus_valid, 0);
    chk("t1_rst_busy", busy, 0);
    chk("t1_rst_cmd_ready", cmd_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    #3 chk("t1_after_rst_req", req, 0);
    chk("t1_after_rst_busy", busy, 0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
